// File: rtl/xbar_alloc.sv
// Switch allocator for the 5-port router crossbar: per-output round-robin
// arbitration with wormhole locking from head to tail flit.
module xbar_alloc #(
   parameter int NPORT = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORT-1:0]     req_vld,
   input  logic [NPORT-1:0]     req_head,
   input  logic [NPORT-1:0]     req_tail,
   input  logic [3*NPORT-1:0]   req_dst,
   input  logic [NPORT-1:0]     out_rdy,
   output logic [NPORT-1:0]     gnt,
   output logic [4*NPORT-1:0]   func,
   output logic [NPORT-1:0]     busy,
   output logic [NPORT-1:0]     err
);

   // Per-output state: r_locked=0 FREE (arbitrate heads), r_locked=1 LOCKED (follow r_owner)
   logic [NPORT-1:0] r_locked;
   logic [NPORT-1:0] r_err;
   logic [2:0]       r_owner [NPORT];
   logic [2:0]       r_ptr   [NPORT];

   logic [NPORT-1:0] w_owns;
   logic [NPORT-1:0] w_legal [NPORT];
   logic [NPORT-1:0] w_xfer;
   logic [NPORT-1:0] w_src_tail;
   logic [2:0]       w_src [NPORT];
   logic [NPORT-1:0] w_err_evt;

   always_comb begin
      w_owns = '0;
      for (int d = 0; d < NPORT; d++)
         for (int i = 0; i < NPORT; i++)
            if (r_locked[d] && r_owner[d] == 3'(i))
               w_owns[i] = 1'b1;
   end

   always_comb begin
      for (int d = 0; d < NPORT; d++)
         for (int i = 0; i < NPORT; i++)
            w_legal[d][i] = req_vld[i] & req_head[i] & ~w_owns[i] &
                            (req_dst[3*i +: 3] == 3'(d)) & (d != i);
   end

   always_comb begin
      logic found;
      logic own_vld;
      int   idx;
      found      = 1'b0;
      own_vld    = 1'b0;
      idx        = 0;
      w_xfer     = '0;
      w_src_tail = '0;
      for (int d = 0; d < NPORT; d++)
         w_src[d] = '0;
      for (int d = 0; d < NPORT; d++) begin
         found   = 1'b0;
         own_vld = 1'b0;
         if (r_locked[d]) begin
            w_src[d] = r_owner[d];
            for (int i = 0; i < NPORT; i++)
               if (r_owner[d] == 3'(i))
                  own_vld = req_vld[i];
            w_xfer[d] = own_vld & out_rdy[d];
         end else begin
            // first legal candidate at or after the pointer wins
            for (int k = 0; k < NPORT; k++) begin
               idx = int'(r_ptr[d]) + k;
               if (idx >= NPORT)
                  idx = idx - NPORT;
               if (!found && w_legal[d][idx]) begin
                  found    = 1'b1;
                  w_src[d] = 3'(idx);
               end
            end
            w_xfer[d] = found & out_rdy[d];
         end
         for (int i = 0; i < NPORT; i++)
            if (w_src[d] == 3'(i))
               w_src_tail[d] = req_tail[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NPORT; i++)
         w_err_evt[i] = req_vld[i] & ~w_owns[i] &
                        (req_head[i] ? ((req_dst[3*i +: 3] == 3'(i)) ||
                                        (req_dst[3*i +: 3] > 3'(NPORT-1)))
                                     : 1'b1);
   end

   // destination NPORT-1 reuses the source's own (otherwise unused) bit
   always_comb begin
      gnt  = '0;
      func = '0;
      if (!rst) begin
         for (int d = 0; d < NPORT; d++)
            for (int s = 0; s < NPORT; s++)
               if (w_xfer[d] && w_src[d] == 3'(s)) begin
                  gnt[s] = 1'b1;
                  func[4*s + ((d == NPORT-1) ? s : d)] = 1'b1;
               end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_locked <= '0;
         r_err    <= '0;
         for (int d = 0; d < NPORT; d++) begin
            r_owner[d] <= '0;
            r_ptr[d]   <= '0;
         end
      end else begin
         for (int d = 0; d < NPORT; d++) begin
            if (w_xfer[d]) begin
               if (r_locked[d]) begin
                  if (w_src_tail[d])
                     r_locked[d] <= 1'b0;
               end else begin
                  r_ptr[d] <= (w_src[d] == 3'(NPORT-1)) ? 3'd0 : w_src[d] + 3'd1;
                  if (!w_src_tail[d]) begin
                     r_locked[d] <= 1'b1;
                     r_owner[d]  <= w_src[d];
                  end
               end
            end
         end
         for (int i = 0; i < NPORT; i++)
            if (w_err_evt[i])
               r_err[i] <= 1'b1;
      end
   end

   assign busy = r_locked;
   assign err  = r_err;

endmodule

// File: tb/tb_xbar_alloc.sv
// Scoreboard bench for xbar_alloc: directed scenarios plus randomized traffic
// against a behavioural model of the allocation rules.
module tb_xbar_alloc;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  req_vld, req_head, req_tail, out_rdy;
   logic [14:0] req_dst;
   logic [4:0]  gnt, busy, err;
   logic [19:0] func;

   xbar_alloc #(.NPORT(5)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_head(req_head),
      .req_tail(req_tail), .req_dst(req_dst), .out_rdy(out_rdy),
      .gnt(gnt), .func(func), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // crossbar bit order per source, listed from nibble bit 3 down to bit 0
   localparam int ORD [5][4] = '{'{3,2,1,4}, '{3,2,4,0}, '{3,4,1,0}, '{4,2,1,0}, '{3,2,1,0}};

   typedef struct {
      logic [4:0]  g;
      logic [19:0] f;
      logic [4:0]  b;
      logic [4:0]  e;
      bit          lit;
      logic [4:0]  lg;
      logic [19:0] lf;
      logic [4:0]  lb;
      logic [4:0]  le;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   bit m_locked [5];
   int m_owner  [5];
   int m_ptr    [5];
   bit m_err    [5];
   int e_src    [5];

   function automatic bit m_owns(int i);
      for (int d = 0; d < 5; d++)
         if (m_locked[d] && m_owner[d] == i) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int dst_of(int i);
      return int'(req_dst[3*i +: 3]);
   endfunction

   function automatic int fbit(int s, int d);
      for (int p = 0; p < 4; p++)
         if (ORD[s][p] == d) return 4*s + (3 - p);
      return 0;
   endfunction

   function automatic logic [14:0] dw(int i, int d);
      logic [14:0] x;
      x = '0;
      x[3*i +: 3] = 3'(d);
      return x;
   endfunction

   task automatic m_eval(output logic [4:0] g, output logic [19:0] f);
      int i;
      g = '0;
      f = '0;
      for (int d = 0; d < 5; d++) begin
         e_src[d] = -1;
         if (m_locked[d]) begin
            if (req_vld[m_owner[d]] && out_rdy[d]) e_src[d] = m_owner[d];
         end else if (out_rdy[d]) begin
            for (int k = 0; k < 5; k++) begin
               i = (m_ptr[d] + k) % 5;
               if (e_src[d] < 0 && req_vld[i] && req_head[i] && dst_of(i) == d &&
                   d != i && !m_owns(i))
                  e_src[d] = i;
            end
         end
      end
      if (!rst)
         for (int d = 0; d < 5; d++)
            if (e_src[d] >= 0) begin
               g[e_src[d]] = 1'b1;
               f[fbit(e_src[d], d)] = 1'b1;
            end
   endtask

   task automatic m_update();
      int s;
      if (rst) begin
         for (int d = 0; d < 5; d++) begin
            m_locked[d] = 1'b0; m_owner[d] = 0; m_ptr[d] = 0; m_err[d] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 5; i++)
            if (req_vld[i] && !m_owns(i)) begin
               if (!req_head[i]) m_err[i] = 1'b1;
               else if (dst_of(i) == i || dst_of(i) > 4) m_err[i] = 1'b1;
            end
         for (int d = 0; d < 5; d++) begin
            s = e_src[d];
            if (s >= 0) begin
               if (m_locked[d]) begin
                  if (req_tail[s]) m_locked[d] = 1'b0;
               end else begin
                  m_ptr[d] = (s + 1) % 5;
                  if (!req_tail[s]) begin
                     m_locked[d] = 1'b1;
                     m_owner[d]  = s;
                  end
               end
            end
         end
      end
   endtask

   task automatic drive(input logic r, input logic [4:0] v, input logic [4:0] h,
                        input logic [4:0] t, input logic [14:0] dst, input logic [4:0] rdy,
                        input bit lit, input logic [4:0] lg, input logic [19:0] lf,
                        input logic [4:0] lb, input logic [4:0] le);
      exp_t x;
      logic [4:0]  g;
      logic [19:0] f;
      rst = r; req_vld = v; req_head = h; req_tail = t; req_dst = dst; out_rdy = rdy;
      m_eval(g, f);
      x.g = g; x.f = f;
      for (int k = 0; k < 5; k++) begin
         x.b[k] = m_locked[k];
         x.e[k] = m_err[k];
      end
      x.lit = lit; x.lg = lg; x.lf = lf; x.lb = lb; x.le = le;
      sb_q.push_back(x);
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic lc(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                     input logic [14:0] dst, input logic [4:0] rdy, input logic [4:0] lg,
                     input logic [19:0] lf, input logic [4:0] lb, input logic [4:0] le);
      drive(1'b0, v, h, t, dst, rdy, 1'b1, lg, lf, lb, le);
   endtask

   task automatic idle();
      drive(1'b0, 5'b0, 5'b0, 5'b0, 15'b0, 5'h1f, 1'b0, 5'b0, 20'b0, 5'b0, 5'b0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("gnt",  32'(gnt),  32'(x.g));
            chk("func", 32'(func), 32'(x.f));
            chk("busy", 32'(busy), 32'(x.b));
            chk("err",  32'(err),  32'(x.e));
            if (x.lit) begin
               chk("lit_gnt",  32'(gnt),  32'(x.lg));
               chk("lit_func", 32'(func), 32'(x.lf));
               chk("lit_busy", 32'(busy), 32'(x.lb));
               chk("lit_err",  32'(err),  32'(x.le));
            end
         end
      end
   end

   initial begin
      logic [4:0]  v, h, t, rdy;
      logic [14:0] dst;
      rst = 1'b1; req_vld = '0; req_head = '0; req_tail = '0; req_dst = '0; out_rdy = '0;
      @(posedge clk);
      m_update();
      #1;

      // single-flit packet, no contention
      lc(5'b00001, 5'b00001, 5'b00001, dw(0,2), 5'h1f, 5'b00001, 20'h00004, 5'b0, 5'b0);
      lc(5'b0, 5'b0, 5'b0, 15'b0, 5'h1f, 5'b0, 20'h0, 5'b0, 5'b0);

      // contention and round-robin on output 0
      dst = dw(1,0) | dw(3,0);
      lc(5'b01010, 5'b01010, 5'b01010, dst, 5'h1f, 5'b00010, 20'h00010, 5'b0, 5'b0);
      lc(5'b01010, 5'b01010, 5'b01010, dst, 5'h1f, 5'b01000, 20'h01000, 5'b0, 5'b0);
      lc(5'b01010, 5'b01010, 5'b01010, dst, 5'h1f, 5'b00010, 20'h00010, 5'b0, 5'b0);
      idle();

      // wormhole lock on output 4
      dst = dw(2,4) | dw(0,4);
      lc(5'b00100, 5'b00100, 5'b00000, dst, 5'h1f, 5'b00100, 20'h00400, 5'b00000, 5'b0);
      lc(5'b00101, 5'b00001, 5'b00000, dst, 5'h1f, 5'b00100, 20'h00400, 5'b10000, 5'b0);
      lc(5'b00101, 5'b00001, 5'b00100, dst, 5'h1f, 5'b00100, 20'h00400, 5'b10000, 5'b0);
      lc(5'b00001, 5'b00001, 5'b00001, dst, 5'h1f, 5'b00001, 20'h00001, 5'b00000, 5'b0);
      idle();

      // backpressure and bubbles on output 3
      dst = dw(0,3);
      lc(5'b00001, 5'b00001, 5'b0, dst, 5'b10111, 5'b0, 20'h0, 5'b0, 5'b0);
      lc(5'b00001, 5'b00001, 5'b0, dst, 5'h1f, 5'b00001, 20'h00008, 5'b0, 5'b0);
      lc(5'b00000, 5'b00000, 5'b0, dst, 5'h1f, 5'b0, 20'h0, 5'b01000, 5'b0);
      lc(5'b00000, 5'b00000, 5'b0, dst, 5'h1f, 5'b0, 20'h0, 5'b01000, 5'b0);
      lc(5'b00001, 5'b00000, 5'b00001, dst, 5'h1f, 5'b00001, 20'h00008, 5'b01000, 5'b0);
      lc(5'b0, 5'b0, 5'b0, 15'b0, 5'h1f, 5'b0, 20'h0, 5'b0, 5'b0);

      // protocol errors
      lc(5'b01000, 5'b01000, 5'b01000, dw(3,3), 5'h1f, 5'b0, 20'h0, 5'b0, 5'b00000);
      lc(5'b00010, 5'b00000, 5'b00000, 15'b0, 5'h1f, 5'b0, 20'h0, 5'b0, 5'b01000);
      lc(5'b0, 5'b0, 5'b0, 15'b0, 5'h1f, 5'b0, 20'h0, 5'b0, 5'b01010);
      lc(5'b0, 5'b0, 5'b0, 15'b0, 5'h1f, 5'b0, 20'h0, 5'b0, 5'b01010);

      // reset mid-packet on output 1
      lc(5'b00001, 5'b00001, 5'b0, dw(0,1), 5'h1f, 5'b00001, 20'h00002, 5'b0, 5'b01010);
      drive(1'b1, 5'b00001, 5'b0, 5'b0, 15'b0, 5'h1f, 1'b1, 5'b0, 20'h0, 5'b00010, 5'b01010);
      lc(5'b00100, 5'b00100, 5'b00100, dw(2,1), 5'h1f, 5'b00100, 20'h00200, 5'b0, 5'b0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 5; i++) begin
            v[i] = ($urandom_range(0, 3) != 0);
            h[i] = m_owns(i) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
            t[i] = ($urandom_range(0, 2) == 0);
            dst[3*i +: 3] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                           : 3'($urandom_range(0, 4));
            rdy[i] = ($urandom_range(0, 3) != 0);
         end
         drive(($urandom_range(0, 49) == 0), v, h, t, dst, rdy, 1'b0, 5'b0, 20'h0, 5'b0, 5'b0);
      end
      idle();

      repeat (2) @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
